// File: rtl/sprite_regs_loader.sv
// ---------------------------------------------------------------------------
// sprite_regs_loader
//
// On a vertical-blank pulse, copies the sprite attribute table
// (4 words per sprite: x, y, shape, enable) from the attribute-table RAM
// into the sprite register file. Words are read in ascending address order
// through a granted read port. Each word is written to register index
// 4n+k exactly two cycles after its read is accepted.
//
// Parameters
//   NUM_SPRITES  number of sprite register sets to load (1..1024)
//   TABLE_BASE   12-bit word address of the first table entry
//
// Ports
//   clk                     clock; all state changes on the rising edge
//   reset_n                 asynchronous active-low reset
//   vblank_start_i          one-cycle load request
//   table_read_o            RAM read request (held until granted)
//   table_addr_o [11:0]     RAM word address
//   table_grant_i           arbiter grant; read accepted on read && grant
//   table_data_i [15:0]     read data, valid one cycle after acceptance
//   register_write_o        sprite register write strobe
//   register_index_o [11:0] sprite register index (0 when not writing)
//   register_write_value_o  sprite register data (0 when not writing)
//   busy_o                  high while a load is in progress (RUN, DRAIN)
//   done_o                  one-cycle pulse when a load completes
//   overrun_o               one-cycle pulse when a request arrives while busy
// ---------------------------------------------------------------------------
module sprite_regs_loader #(
  parameter int          NUM_SPRITES = 8,
  parameter logic [11:0] TABLE_BASE  = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vblank_start_i,
  output logic        table_read_o,
  output logic [11:0] table_addr_o,
  input  logic        table_grant_i,
  input  logic [15:0] table_data_i,
  output logic        register_write_o,
  output logic [11:0] register_index_o,
  output logic [15:0] register_write_value_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);

  localparam int          WORDS     = 4 * NUM_SPRITES;
  // Index of the final word; fits in 12 bits even for 1024 sprites.
  localparam logic [11:0] LAST_WORD = 12'(WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [11:0] addr_reg;      // next table address to request
  logic [11:0] rd_cnt_reg;    // number of words accepted so far
  logic [11:0] idx_cnt_reg;   // register index of the next captured word
  logic        pend_reg;      // read accepted last cycle: data valid now
  logic        wr_reg;
  logic [11:0] index_reg;
  logic [15:0] value_reg;
  logic        overrun_reg;
  logic        accept;

  assign accept = (state_reg == S_RUN) && table_grant_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (vblank_start_i) state_next = S_RUN;
      S_RUN:   if (accept && (rd_cnt_reg == LAST_WORD)) state_next = S_DRAIN;
      // The last write is the only one carrying LAST_WORD as its index.
      S_DRAIN: if (wr_reg && (index_reg == LAST_WORD)) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      addr_reg    <= 12'd0;
      rd_cnt_reg  <= 12'd0;
      idx_cnt_reg <= 12'd0;
      pend_reg    <= 1'b0;
      wr_reg      <= 1'b0;
      index_reg   <= 12'd0;
      value_reg   <= 16'd0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      overrun_reg <= vblank_start_i && (state_reg != S_IDLE);
      pend_reg    <= accept;

      if ((state_reg == S_IDLE) && vblank_start_i) begin
        addr_reg    <= TABLE_BASE;
        rd_cnt_reg  <= 12'd0;
        idx_cnt_reg <= 12'd0;
      end else if (accept) begin
        addr_reg   <= addr_reg + 12'd1;
        rd_cnt_reg <= rd_cnt_reg + 12'd1;
      end

      // Capture stage: data arriving this cycle is written next cycle.
      // Index and value are zeroed in non-write cycles.
      wr_reg <= pend_reg;
      if (pend_reg) begin
        value_reg   <= table_data_i;
        index_reg   <= idx_cnt_reg;
        idx_cnt_reg <= idx_cnt_reg + 12'd1;
      end else begin
        value_reg <= 16'd0;
        index_reg <= 12'd0;
      end
    end
  end

  assign table_read_o           = (state_reg == S_RUN);
  assign table_addr_o           = (state_reg == S_RUN) ? addr_reg : 12'd0;
  assign register_write_o       = wr_reg;
  assign register_index_o       = index_reg;
  assign register_write_value_o = value_reg;
  assign busy_o                 = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done_o                 = (state_reg == S_DONE);
  assign overrun_o              = overrun_reg;

endmodule

// File: tb/tb_sprite_regs_loader.sv
// ---------------------------------------------------------------------------
// tb_sprite_regs_loader
//
// Two instances: A (8 sprites, table at 0x100) and B (1 sprite, table at
// 0xFFC). A small RAM model answers granted reads one cycle later. Negedge
// monitors log writes, done/overrun pulses and busy cycles; each test task
// compares the logged activity against hand-derived cycle numbers.
// ---------------------------------------------------------------------------
module tb_sprite_regs_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_n = 0;
  int total_n = 0;

  logic [15:0] ram [4096];

  function automatic logic [15:0] exp_word(input int a);
    return 16'(a * 40503) ^ 16'hC3A5;
  endfunction

  // DUT A
  logic        vb_a = 1'b0, rd_a, gnt_a, wr_a, busy_a, done_a, ovr_a;
  logic [11:0] addr_a, idx_a;
  logic [15:0] data_a = 16'd0, val_a;
  bit          gmode = 1'b0;
  assign gnt_a = gmode ? cyc[0] : 1'b1;

  sprite_regs_loader #(.NUM_SPRITES(8), .TABLE_BASE(12'h100)) dut_a (
    .clk(clk), .reset_n(reset_n), .vblank_start_i(vb_a),
    .table_read_o(rd_a), .table_addr_o(addr_a), .table_grant_i(gnt_a),
    .table_data_i(data_a), .register_write_o(wr_a), .register_index_o(idx_a),
    .register_write_value_o(val_a), .busy_o(busy_a), .done_o(done_a),
    .overrun_o(ovr_a));

  // DUT B
  logic        vb_b = 1'b0, rd_b, wr_b, busy_b, done_b, ovr_b;
  logic [11:0] addr_b, idx_b;
  logic [15:0] data_b = 16'd0, val_b;

  sprite_regs_loader #(.NUM_SPRITES(1), .TABLE_BASE(12'hFFC)) dut_b (
    .clk(clk), .reset_n(reset_n), .vblank_start_i(vb_b),
    .table_read_o(rd_b), .table_addr_o(addr_b), .table_grant_i(1'b1),
    .table_data_i(data_b), .register_write_o(wr_b), .register_index_o(idx_b),
    .register_write_value_o(val_b), .busy_o(busy_b), .done_o(done_b),
    .overrun_o(ovr_b));

  always @(posedge clk) begin
    if (rd_a && gnt_a) data_a <= ram[addr_a];
    if (rd_b)          data_b <= ram[addr_b];
  end

  // Monitors
  logic [11:0] wa_idx [256];
  logic [15:0] wa_val [256];
  int          wa_cyc [256];
  int wa_n = 0, da_n = 0, da_cyc = 0, oa_n = 0, oa_cyc = 0, ba_n = 0, zv_n = 0;
  logic [11:0] wb_idx [16];
  logic [15:0] wb_val [16];
  int          wb_cyc [16];
  int wb_n = 0, db_n = 0, db_cyc = 0;

  always @(negedge clk) begin
    if (wr_a) begin
      if (wa_n < 256) begin
        wa_idx[wa_n] <= idx_a; wa_val[wa_n] <= val_a; wa_cyc[wa_n] <= cyc;
      end
      wa_n <= wa_n + 1;
    end else if (idx_a !== 12'd0 || val_a !== 16'd0) begin
      zv_n <= zv_n + 1;
    end
    if (done_a) begin da_n <= da_n + 1; da_cyc <= cyc; end
    if (ovr_a)  begin oa_n <= oa_n + 1; oa_cyc <= cyc; end
    if (busy_a) ba_n <= ba_n + 1;
    if (wr_b) begin
      if (wb_n < 16) begin
        wb_idx[wb_n] <= idx_b; wb_val[wb_n] <= val_b; wb_cyc[wb_n] <= cyc;
      end
      wb_n <= wb_n + 1;
    end
    if (done_b) begin db_n <= db_n + 1; db_cyc <= cyc; end
  end

  task automatic start_a(output int t);
    @(posedge clk); #1 vb_a = 1'b1; t = cyc;
    @(posedge clk); #1 vb_a = 1'b0;
  endtask

  task automatic wait_done_a(input int d0);
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk); #1;
      if (da_n > d0) ok = 1'b1;
    end
    total_n++;
    if (!ok) $display("FAIL done_timeout_a: got no done_o within 300 cycles, want one");
    else pass_n++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    total_n++;
    if ({rd_a, addr_a, wr_a, idx_a, val_a, busy_a, done_a, ovr_a} !== 61'd0) begin
      $display("FAIL reset_outputs_a: got rd=%b addr=%h wr=%b busy=%b done=%b, want all 0",
               rd_a, addr_a, wr_a, busy_a, done_a);
    end else pass_n++;
    total_n++;
    if ({rd_b, addr_b, wr_b, idx_b, val_b, busy_b, done_b, ovr_b} !== 61'd0) begin
      $display("FAIL reset_outputs_b: got rd=%b wr=%b busy=%b, want all 0", rd_b, wr_b, busy_b);
    end else pass_n++;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    total_n++;
    if (wa_n !== 0 || busy_a !== 1'b0) begin
      $display("FAIL idle_after_reset: got writes=%0d busy=%b, want 0 0", wa_n, busy_a);
    end else pass_n++;
  endtask

  task automatic test_full_load;
    int t, w0, d0, b0, o0, z0;
    w0 = wa_n; d0 = da_n; b0 = ba_n; o0 = oa_n; z0 = zv_n;
    start_a(t);
    wait_done_a(d0);
    repeat (3) @(negedge clk);
    #1;
    total_n++;
    if (wa_n - w0 !== 32) $display("FAIL full_count: got %0d writes, want 32", wa_n - w0);
    else pass_n++;
    for (int i = 0; i < 32; i++) begin
      total_n++;
      if (wa_idx[w0+i] !== 12'(i) || wa_val[w0+i] !== exp_word(12'h100 + i) ||
          wa_cyc[w0+i] !== t + 3 + i) begin
        $display("FAIL full_write[%0d]: got idx=%0d val=%h cyc=%0d, want idx=%0d val=%h cyc=%0d",
                 i, wa_idx[w0+i], wa_val[w0+i], wa_cyc[w0+i], i, exp_word(12'h100 + i), t + 3 + i);
      end else pass_n++;
    end
    total_n++;
    if (da_cyc !== t + 35) $display("FAIL full_done_cycle: got %0d, want %0d", da_cyc, t + 35);
    else pass_n++;
    total_n++;
    if (ba_n - b0 !== 34) $display("FAIL full_busy_cycles: got %0d, want 34", ba_n - b0);
    else pass_n++;
    total_n++;
    if (zv_n !== z0 || oa_n !== o0) begin
      $display("FAIL full_idle_zero: got zero_violations=%0d overruns=%0d, want 0 0",
               zv_n - z0, oa_n - o0);
    end else pass_n++;
  endtask

  task automatic test_grant_toggle;
    int t, w0, d0;
    w0 = wa_n; d0 = da_n;
    gmode = 1'b1;
    start_a(t);
    wait_done_a(d0);
    gmode = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_n++;
    if (wa_n - w0 !== 32) $display("FAIL toggle_count: got %0d writes, want 32", wa_n - w0);
    else pass_n++;
    for (int i = 0; i < 32; i++) begin
      total_n++;
      if (wa_idx[w0+i] !== 12'(i) || wa_val[w0+i] !== exp_word(12'h100 + i)) begin
        $display("FAIL toggle_write[%0d]: got idx=%0d val=%h, want idx=%0d val=%h",
                 i, wa_idx[w0+i], wa_val[w0+i], i, exp_word(12'h100 + i));
      end else pass_n++;
    end
    total_n++;
    if (da_cyc !== wa_cyc[w0+31] + 1 || da_cyc <= t + 35) begin
      $display("FAIL toggle_done_cycle: got %0d, want %0d (after stalls)", da_cyc, wa_cyc[w0+31] + 1);
    end else pass_n++;
  endtask

  task automatic test_overrun;
    int t, w0, d0, o0;
    w0 = wa_n; d0 = da_n; o0 = oa_n;
    start_a(t);
    repeat (9) @(posedge clk);
    #1 vb_a = 1'b1;
    @(posedge clk); #1 vb_a = 1'b0;
    wait_done_a(d0);
    repeat (15) @(negedge clk);
    #1;
    total_n++;
    if (oa_n - o0 !== 1 || oa_cyc !== t + 11) begin
      $display("FAIL overrun_pulse: got count=%0d cyc=%0d, want count=1 cyc=%0d",
               oa_n - o0, oa_cyc, t + 11);
    end else pass_n++;
    total_n++;
    if (wa_n - w0 !== 32 || da_n - d0 !== 1) begin
      $display("FAIL overrun_single_load: got writes=%0d dones=%0d, want 32 1", wa_n - w0, da_n - d0);
    end else pass_n++;
    total_n++;
    if (da_cyc !== t + 35) $display("FAIL overrun_done_cycle: got %0d, want %0d", da_cyc, t + 35);
    else pass_n++;
  endtask

  task automatic test_reset_midload;
    int t, w0, d0;
    bit ok = 1'b0;
    w0 = wa_n;
    start_a(t);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); #1;
      if (wa_n - w0 >= 5) ok = 1'b1;
    end
    total_n++;
    if (!ok) $display("FAIL midload_5th_write: got %0d writes before timeout, want 5", wa_n - w0);
    else pass_n++;
    reset_n = 1'b0;
    #1;
    total_n++;
    if ({rd_a, addr_a, wr_a, idx_a, val_a, busy_a, done_a, ovr_a} !== 61'd0) begin
      $display("FAIL midload_reset_outputs: got rd=%b addr=%h wr=%b idx=%0d busy=%b, want all 0",
               rd_a, addr_a, wr_a, idx_a, busy_a);
    end else pass_n++;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    total_n++;
    if (wa_n - w0 !== 5 || busy_a !== 1'b0) begin
      $display("FAIL midload_no_more_writes: got writes=%0d busy=%b, want 5 0", wa_n - w0, busy_a);
    end else pass_n++;
    w0 = wa_n; d0 = da_n;
    start_a(t);
    wait_done_a(d0);
    repeat (3) @(negedge clk);
    #1;
    total_n++;
    if (wa_n - w0 !== 32) $display("FAIL reload_count: got %0d writes, want 32", wa_n - w0);
    else pass_n++;
    for (int i = 0; i < 32; i++) begin
      total_n++;
      if (wa_idx[w0+i] !== 12'(i) || wa_val[w0+i] !== exp_word(12'h100 + i) ||
          wa_cyc[w0+i] !== t + 3 + i) begin
        $display("FAIL reload_write[%0d]: got idx=%0d val=%h cyc=%0d, want idx=%0d val=%h cyc=%0d",
                 i, wa_idx[w0+i], wa_val[w0+i], wa_cyc[w0+i], i, exp_word(12'h100 + i), t + 3 + i);
      end else pass_n++;
    end
  endtask

  task automatic test_single_sprite;
    int t;
    bit ok = 1'b0;
    logic [15:0] want [4];
    want[0] = 16'h0010; want[1] = 16'h0020; want[2] = 16'h0003; want[3] = 16'h0001;
    @(posedge clk); #1 vb_b = 1'b1; t = cyc;
    @(posedge clk); #1 vb_b = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk); #1;
      if (db_n > 0) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    total_n++;
    if (!ok || db_cyc !== t + 7) $display("FAIL n1_done_cycle: got %0d, want %0d", db_cyc, t + 7);
    else pass_n++;
    total_n++;
    if (wb_n !== 4) $display("FAIL n1_count: got %0d writes, want 4", wb_n);
    else pass_n++;
    for (int i = 0; i < 4; i++) begin
      total_n++;
      if (wb_idx[i] !== 12'(i) || wb_val[i] !== want[i] || wb_cyc[i] !== t + 3 + i) begin
        $display("FAIL n1_write[%0d]: got idx=%0d val=%h cyc=%0d, want idx=%0d val=%h cyc=%0d",
                 i, wb_idx[i], wb_val[i], wb_cyc[i], i, want[i], t + 3 + i);
      end else pass_n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = exp_word(i);
    ram[12'hFFC] = 16'h0010;
    ram[12'hFFD] = 16'h0020;
    ram[12'hFFE] = 16'h0003;
    ram[12'hFFF] = 16'h0001;
    test_reset();
    test_full_load();
    test_grant_toggle();
    test_overrun();
    test_reset_midload();
    test_single_sprite();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
